// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for the shared data-memory / IO bus: CPU port has priority,
// the aux port is guaranteed one grant after STARVE_MAX consecutive losses.
module mem_bus_arbiter #(
  parameter logic [31:0] DM_LIMIT   = 32'h0000_3000,
  parameter logic [31:0] IO_BASE    = 32'h0000_7F00,
  parameter logic [31:0] IO_LIMIT   = 32'h0000_7F1F,
  parameter int          TIMEOUT    = 16,
  parameter int          STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        cpu_stall,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [31:0] aux_addr,
  input  logic [3:0]  aux_be,
  input  logic [31:0] aux_wdata,
  output logic [31:0] aux_rdata,
  output logic        aux_done,
  output logic        aux_err,
  output logic        dm_en,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  output logic        io_req,
  output logic        io_we,
  output logic [29:0] io_addr,
  output logic [3:0]  io_be,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata,
  input  logic        io_ack
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DM_ACC,
    S_IO_WAIT,
    S_ERR_RSP,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic [31:0]   aux_rdata_q, aux_rdata_d;
  logic          err_q, err_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          grant_aux;
  logic [31:0]   sel_addr;
  logic          load_wr;
  logic [31:0]   load_val;

  function automatic state_t decode(input logic [31:0] a);
    if (a < DM_LIMIT)                    return S_DM_ACC;
    else if (a >= IO_BASE && a <= IO_LIMIT) return S_IO_WAIT;
    else                                 return S_ERR_RSP;
  endfunction

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    aux_rdata_d = aux_rdata_q;
    err_d       = err_q;
    tcnt_d      = tcnt_q;
    starve_d    = starve_q;
    grant_aux   = 1'b0;
    sel_addr    = cpu_addr;
    load_wr     = 1'b0;
    load_val    = 32'h0;
    dm_en       = 1'b0;
    dm_we       = 1'b0;
    dm_addr     = 32'h0;
    dm_be       = 4'h0;
    dm_wdata    = 32'h0;
    io_req      = 1'b0;
    io_we       = 1'b0;
    io_addr     = 30'h0;
    io_be       = 4'h0;
    io_wdata    = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req || aux_req) begin
          grant_aux = aux_req && (!cpu_req || starve_q == STARVE_LIM);
          sel_addr  = grant_aux ? aux_addr : cpu_addr;
          owner_d   = grant_aux;
          we_d      = grant_aux ? aux_we : cpu_we;
          addr_d    = sel_addr;
          be_d      = grant_aux ? aux_be : cpu_be;
          wdata_d   = grant_aux ? aux_wdata : cpu_wdata;
          err_d     = 1'b0;
          tcnt_d    = '0;
          if (grant_aux)
            starve_d = '0;
          else if (aux_req)
            starve_d = starve_q + 1'b1;
          state_d = decode(sel_addr);
        end
      end
      S_DM_ACC: begin
        dm_en    = 1'b1;
        dm_we    = we_q;
        dm_addr  = addr_q;
        dm_be    = be_q;
        dm_wdata = wdata_q;
        load_wr  = !we_q;
        load_val = dm_rdata;
        state_d  = S_RESP;
      end
      S_IO_WAIT: begin
        io_req   = 1'b1;
        io_we    = we_q;
        io_addr  = addr_q[31:2];
        io_be    = be_q;
        io_wdata = wdata_q;
        if (io_ack) begin
          load_wr  = !we_q;
          load_val = io_rdata;
          state_d  = S_RESP;
        end else if (tcnt_q == TCNT_LAST) begin
          err_d   = 1'b1;
          load_wr = !we_q;
          state_d = S_RESP;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_ERR_RSP: begin
        err_d   = 1'b1;
        load_wr = !we_q;
        state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Only loads land in the owner's read-data register; stores leave it untouched.
    if (load_wr) begin
      if (owner_q)
        aux_rdata_d = load_val;
      else
        cpu_rdata_d = load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      cpu_rdata_q <= 32'h0;
      aux_rdata_q <= 32'h0;
      err_q       <= 1'b0;
      tcnt_q      <= '0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      aux_rdata_q <= aux_rdata_d;
      err_q       <= err_d;
      tcnt_q      <= tcnt_d;
      starve_q    <= starve_d;
    end
  end

  assign cpu_done  = (state_q == S_RESP) && !owner_q;
  assign aux_done  = (state_q == S_RESP) && owner_q;
  assign cpu_err   = cpu_done && err_q;
  assign aux_err   = aux_done && err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign aux_rdata = aux_rdata_q;
  assign cpu_stall = cpu_req && !cpu_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter with a transaction-level model of
// arbitration, address decode, latency and read-data behaviour.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, aux_req, aux_we;
  logic [31:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
  logic [3:0]  cpu_be, aux_be;
  logic [31:0] cpu_rdata, aux_rdata;
  logic        cpu_done, cpu_err, cpu_stall, aux_done, aux_err;
  logic        dm_en, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        io_req, io_we, io_ack;
  logic [29:0] io_addr;
  logic [3:0]  io_be;
  logic [31:0] io_wdata, io_rdata;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .cpu_err(cpu_err), .cpu_stall(cpu_stall),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_be(aux_be),
    .aux_wdata(aux_wdata), .aux_rdata(aux_rdata), .aux_done(aux_done),
    .aux_err(aux_err),
    .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_be(io_be),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack)
  );

  // DM read data is a fixed function of the address, so expected load data
  // follows from the request alone.
  function automatic logic [31:0] dm_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  assign dm_rdata = dm_word(dm_addr);

  typedef struct packed {
    logic        pend;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  localparam int REG_DM  = 0;
  localparam int REG_IO  = 1;
  localparam int REG_ERR = 2;

  int          total = 0;
  int          bad   = 0;
  req_t        cpu_r, aux_r;
  int          starve_m;
  logic [31:0] exp_cpu_rd, exp_aux_rd;

  function automatic int region(input logic [31:0] a);
    if (a < 32'h0000_3000) return REG_DM;
    if (a >= 32'h0000_7F00 && a <= 32'h0000_7F1F) return REG_IO;
    return REG_ERR;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic make_req(output req_t r);
    int sel;
    sel     = $urandom_range(0, 9);
    r.pend  = 1'b1;
    r.we    = 1'($urandom_range(0, 1));
    r.be    = 4'($urandom);
    r.wdata = $urandom;
    case (sel)
      0, 1, 2, 3, 4: r.addr = 32'($urandom_range(0, 32'h2FFF));
      5: r.addr = 32'h0000_2FFC;
      6: r.addr = 32'h0000_7F00 + 32'($urandom_range(0, 31));
      7: r.addr = ($urandom_range(0, 1) == 1) ? 32'h0000_7F1F : 32'h0000_7F00;
      8: begin
        case ($urandom_range(0, 2))
          0: r.addr = 32'h0000_3000;
          1: r.addr = 32'h0000_7EFF;
          default: r.addr = 32'h0000_7F20;
        endcase
      end
      default: r.addr = $urandom;
    endcase
    if (region(r.addr) == REG_ERR) r.we = 1'b0;
  endtask

  task automatic drive_inputs();
    cpu_req = cpu_r.pend; cpu_we = cpu_r.we; cpu_addr = cpu_r.addr;
    cpu_be  = cpu_r.be;   cpu_wdata = cpu_r.wdata;
    aux_req = aux_r.pend; aux_we = aux_r.we; aux_addr = aux_r.addr;
    aux_be  = aux_r.be;   aux_wdata = aux_r.wdata;
  endtask

  // One arbitration round from an IDLE cycle through RESP and back to IDLE.
  // ack_delay = io_req cycle in which io_ack is raised; above 16 means never.
  task automatic applyStimulus(input int ack_delay, output logic owner_aux);
    req_t         cur;
    int           rg, d, done_at;
    logic         exp_err;
    logic [31:0]  io_data;
    logic [127:0] exp_dm, exp_io;
    logic         exp_stall;

    drive_inputs();
    owner_aux = aux_r.pend && (!cpu_r.pend || starve_m == 4);
    if (owner_aux) starve_m = 0;
    else if (aux_r.pend) starve_m++;
    cur = owner_aux ? aux_r : cpu_r;
    rg  = region(cur.addr);
    d   = ack_delay;
    if (rg == REG_IO && cur.we && d > 16) d = 16;
    if (rg == REG_IO) done_at = (d <= 16) ? d + 1 : 17;
    else done_at = 2;
    exp_err  = (rg == REG_ERR) || (rg == REG_IO && d > 16);
    io_data  = $urandom;
    io_rdata = io_data;

    for (int k = 1; k <= done_at; k++) begin
      @(posedge clk); #1;
      io_ack = 1'b0;
      exp_dm = (rg == REG_DM && k == 1) ? {1'b1, cur.we, cur.addr, cur.be, cur.wdata} : '0;
      exp_io = (rg == REG_IO && k < done_at) ? {1'b1, cur.we, cur.addr[31:2], cur.be, cur.wdata} : '0;
      checkOutput("dm_bus", {dm_en, dm_we, dm_addr, dm_be, dm_wdata}, exp_dm);
      checkOutput("io_bus", {io_req, io_we, io_addr, io_be, io_wdata}, exp_io);
      exp_stall = cpu_r.pend && !(k == done_at && !owner_aux);
      checkOutput("cpu_stall", cpu_stall, exp_stall);
      if (k == done_at) begin
        checkOutput("done", {aux_done, cpu_done}, owner_aux ? 2'b10 : 2'b01);
        checkOutput("err", {aux_err, cpu_err}, owner_aux ? {exp_err, 1'b0} : {1'b0, exp_err});
        if (!cur.we) begin
          if (owner_aux)
            exp_aux_rd = (rg == REG_DM) ? dm_word(cur.addr) : (exp_err ? 32'h0 : io_data);
          else
            exp_cpu_rd = (rg == REG_DM) ? dm_word(cur.addr) : (exp_err ? 32'h0 : io_data);
        end
        checkOutput("cpu_rdata", cpu_rdata, exp_cpu_rd);
        checkOutput("aux_rdata", aux_rdata, exp_aux_rd);
      end else begin
        checkOutput("done_early", {aux_done, cpu_done}, 2'b00);
        if (rg == REG_IO && k == d) io_ack = 1'b1;
        else if (rg != REG_IO) io_ack = 1'($urandom_range(0, 1));
      end
    end
    io_ack = 1'b0;
    if (owner_aux) aux_r.pend = 1'b0;
    else cpu_r.pend = 1'b0;
    // Owner's request is still held through RESP; it must not start a new access.
    @(posedge clk); #1;
    checkOutput("idle_quiet", {cpu_done, aux_done, dm_en, io_req}, 4'h0);
  endtask

  initial begin
    logic       o;
    logic [5:0] winners;

    reset = 1'b1; io_ack = 1'b0; io_rdata = 32'h0;
    cpu_r = '0; aux_r = '0; starve_m = 0;
    exp_cpu_rd = 32'h0; exp_aux_rd = 32'h0;
    drive_inputs();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outs", {cpu_done, cpu_err, aux_done, aux_err, cpu_stall,
                               dm_en, dm_we, io_req, io_we}, 9'h0);
    checkOutput("reset_rdata", {cpu_rdata, aux_rdata}, 64'h0);
    checkOutput("reset_bus", {dm_addr, dm_be, dm_wdata, io_addr, io_be, io_wdata}, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    cpu_r = '{pend: 1'b1, we: 1'b0, addr: 32'h10, be: 4'hF, wdata: 32'h0};
    applyStimulus(1, o);
    checkOutput("lw_deadbeef", cpu_rdata, 32'hDEAD_BEEF);

    aux_r = '{pend: 1'b1, we: 1'b0, addr: 32'h0000_0100, be: 4'hF, wdata: 32'h0};
    for (int i = 0; i < 6; i++) begin
      if (!cpu_r.pend)
        cpu_r = '{pend: 1'b1, we: 1'b0, addr: 32'h0000_0200 + 32'(i * 4), be: 4'hF, wdata: 32'h0};
      applyStimulus(1, o);
      winners[i] = o;
    end
    checkOutput("starve_order", winners, 6'b010000);

    cpu_r = '{pend: 1'b1, we: 1'b1, addr: 32'h0000_7F04, be: 4'h3, wdata: 32'hCAFE_F00D};
    applyStimulus(3, o);

    cpu_r = '{pend: 1'b1, we: 1'b0, addr: 32'h0000_7F08, be: 4'hF, wdata: 32'h0};
    applyStimulus(99, o);
    checkOutput("timeout_rdata", cpu_rdata, 32'h0);

    aux_r = '{pend: 1'b1, we: 1'b0, addr: 32'h0000_5000, be: 4'hF, wdata: 32'h0};
    applyStimulus(1, o);

    cpu_r = '{pend: 1'b1, we: 1'b0, addr: 32'h0000_7F00, be: 4'hF, wdata: 32'h0};
    drive_inputs();
    repeat (4) @(posedge clk);
    #1;
    checkOutput("io_req_before_reset", io_req, 1'b1);
    reset = 1'b1;
    cpu_r = '0; aux_r = '0;
    drive_inputs();
    @(posedge clk); #1;
    starve_m = 0; exp_cpu_rd = 32'h0; exp_aux_rd = 32'h0;
    checkOutput("midreset_outs", {cpu_done, aux_done, cpu_err, aux_err, dm_en, io_req}, 6'h0);
    checkOutput("midreset_rdata", {cpu_rdata, aux_rdata}, 64'h0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("postreset_nodone", {cpu_done, aux_done, io_req, dm_en}, 4'h0);
    end

    for (int r = 0; r < 150; r++) begin
      if (!cpu_r.pend && $urandom_range(0, 2) != 0) make_req(cpu_r);
      if (!aux_r.pend && $urandom_range(0, 2) != 0) make_req(aux_r);
      if (!cpu_r.pend && !aux_r.pend) begin
        if ($urandom_range(0, 1) == 1) make_req(cpu_r);
        else make_req(aux_r);
      end
      applyStimulus($urandom_range(1, 20), o);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
